// File: rtl/adc_conv_scheduler.sv
// Conversion scheduler for the discrete SAR ADC: sweeps enabled channels every
// SAMPLE_PERIOD cycles, averages 2^AVG_LOG2 SAR conversions per channel.
module adc_conv_scheduler #(
   parameter int NUM_CH        = 4,
   parameter int SAMPLE_PERIOD = 1000,
   parameter int SETTLE_CYCLES = 8,
   parameter int AVG_LOG2      = 2,
   parameter int TIMEOUT       = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      run,
   input  logic [NUM_CH-1:0]         ch_mask,
   output logic [$clog2(NUM_CH)-1:0] mux_sel,
   output logic                      sh_hold,
   output logic                      sar_enable,
   input  logic                      sar_done,
   input  logic [7:0]                sar_result,
   output logic [7:0]                res_data,
   output logic [$clog2(NUM_CH)-1:0] res_ch,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic                      busy,
   output logic                      overrun,
   output logic                      tick_miss,
   output logic                      timeout_err
);

   localparam int CH_W   = $clog2(NUM_CH);
   localparam int TICK_W = $clog2(SAMPLE_PERIOD);
   localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
   localparam int TO_W   = $clog2(TIMEOUT + 1);
   localparam int ACC_W  = 8 + AVG_LOG2;
   localparam int CNV_W  = AVG_LOG2 + 1;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_PERIOD - 1);
   localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
   localparam logic [CNV_W-1:0]  CNV_LAST  = CNV_W'((1 << AVG_LOG2) - 1);
   localparam logic [CNV_W-1:0]  CNV_ALL   = CNV_W'(1 << AVG_LOG2);

   typedef enum logic [2:0] {IDLE, WAIT_TICK, SETTLE, CONVERT, TRACK} state_t;

   state_t              state_q, state_d;
   logic [TICK_W-1:0]   tickCnt_q, tickCnt_d;
   logic [NUM_CH-1:0]   mask_q, mask_d;
   logic [CH_W-1:0]     chan_q, chan_d;
   logic [SET_W-1:0]    setCnt_q, setCnt_d;
   logic [TO_W-1:0]     toCnt_q, toCnt_d;
   logic [CNV_W-1:0]    cnv_q, cnv_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [7:0]          resData_q, resData_d;
   logic [CH_W-1:0]     resCh_q, resCh_d;
   logic                resValid_q, resValid_d;
   logic                overrun_q, overrun_d;
   logic                tickMiss_q, tickMiss_d;
   logic                timeoutErr_q, timeoutErr_d;

   logic                tick;
   logic                busyNow;
   logic                load;
   logic [ACC_W-1:0]    sum;
   logic [CH_W-1:0]     firstCh, nextCh;
   logic                firstValid, nextValid;

   assign tick    = run && (state_q != IDLE) && (tickCnt_q == TICK_LAST);
   assign busyNow = (state_q == SETTLE) || (state_q == CONVERT) || (state_q == TRACK);
   assign sum     = acc_q + ACC_W'(sar_result);

   // Lowest enabled channel at a tick, and the next enabled channel above the current one.
   always_comb begin
      firstCh    = '0;
      firstValid = 1'b0;
      nextCh     = '0;
      nextValid  = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (ch_mask[i]) begin
            firstCh    = CH_W'(i);
            firstValid = 1'b1;
         end
         if (mask_q[i] && (i > int'(chan_q))) begin
            nextCh    = CH_W'(i);
            nextValid = 1'b1;
         end
      end
   end

   // Sweep sequencing, averaging and result handshake; dropping run overrides everything
   // except a result already waiting for the consumer.
   always_comb begin
      state_d      = state_q;
      mask_d       = mask_q;
      chan_d       = chan_q;
      setCnt_d     = setCnt_q;
      toCnt_d      = toCnt_q;
      cnv_d        = cnv_q;
      acc_d        = acc_q;
      resData_d    = resData_q;
      resCh_d      = resCh_q;
      resValid_d   = resValid_q;
      overrun_d    = 1'b0;
      timeoutErr_d = 1'b0;
      load         = 1'b0;
      tickMiss_d   = tick && busyNow;

      if (state_q == IDLE) begin
         tickCnt_d = run ? TICK_LAST : '0;
      end else if (!run) begin
         tickCnt_d = '0;
      end else begin
         tickCnt_d = (tickCnt_q == TICK_LAST) ? '0 : tickCnt_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (run) state_d = WAIT_TICK;
         end
         WAIT_TICK: begin
            if (tick) begin
               mask_d = ch_mask;
               if (firstValid) begin
                  chan_d   = firstCh;
                  setCnt_d = '0;
                  state_d  = SETTLE;
               end
            end
         end
         SETTLE: begin
            if (setCnt_q == SET_LAST) begin
               toCnt_d = '0;
               state_d = CONVERT;
            end else begin
               setCnt_d = setCnt_q + 1'b1;
            end
         end
         CONVERT: begin
            if (sar_done) begin
               cnv_d   = cnv_q + 1'b1;
               state_d = TRACK;
               if (cnv_q == CNV_LAST) begin
                  load  = 1'b1;
                  acc_d = '0;
               end else begin
                  acc_d = sum;
               end
            end else if (toCnt_q == TO_LAST) begin
               timeoutErr_d = 1'b1;
               acc_d        = '0;
               cnv_d        = '0;
               state_d      = WAIT_TICK;
            end else begin
               toCnt_d = toCnt_q + 1'b1;
            end
         end
         TRACK: begin
            if (cnv_q != CNV_ALL) begin
               toCnt_d = '0;
               state_d = CONVERT;
            end else begin
               cnv_d = '0;
               if (nextValid) begin
                  chan_d   = nextCh;
                  setCnt_d = '0;
                  state_d  = SETTLE;
               end else begin
                  state_d = WAIT_TICK;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (!run) begin
         state_d      = IDLE;
         chan_d       = '0;
         setCnt_d     = '0;
         toCnt_d      = '0;
         cnv_d        = '0;
         acc_d        = '0;
         load         = 1'b0;
         timeoutErr_d = 1'b0;
      end

      if (load) begin
         resData_d  = sum[ACC_W-1:AVG_LOG2];
         resCh_d    = chan_q;
         resValid_d = 1'b1;
         overrun_d  = resValid_q && !res_ready;
      end else if (resValid_q && res_ready) begin
         resValid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         tickCnt_q    <= '0;
         mask_q       <= '0;
         chan_q       <= '0;
         setCnt_q     <= '0;
         toCnt_q      <= '0;
         cnv_q        <= '0;
         acc_q        <= '0;
         resData_q    <= '0;
         resCh_q      <= '0;
         resValid_q   <= 1'b0;
         overrun_q    <= 1'b0;
         tickMiss_q   <= 1'b0;
         timeoutErr_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         tickCnt_q    <= tickCnt_d;
         mask_q       <= mask_d;
         chan_q       <= chan_d;
         setCnt_q     <= setCnt_d;
         toCnt_q      <= toCnt_d;
         cnv_q        <= cnv_d;
         acc_q        <= acc_d;
         resData_q    <= resData_d;
         resCh_q      <= resCh_d;
         resValid_q   <= resValid_d;
         overrun_q    <= overrun_d;
         tickMiss_q   <= tickMiss_d;
         timeoutErr_q <= timeoutErr_d;
      end
   end

   assign mux_sel     = chan_q;
   assign sh_hold     = (state_q == CONVERT);
   assign sar_enable  = (state_q == CONVERT);
   assign busy        = busyNow;
   assign res_data    = resData_q;
   assign res_ch      = resCh_q;
   assign res_valid   = resValid_q;
   assign overrun     = overrun_q;
   assign tick_miss   = tickMiss_q;
   assign timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Directed-sequence bench for adc_conv_scheduler with random SAR codes; expected
// averages come from a per-channel code table summed with plain arithmetic.
module tb_adc_conv_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       run, runB;
   logic [3:0] chMask, chMaskB;
   logic       resReady;

   logic [1:0] muxSel, resCh, muxSelB, resChB;
   logic       shHold, sarEnable, sarDone, resValid, busy, overrun, tickMiss, timeoutErr;
   logic       shHoldB, sarEnableB, sarDoneB, resValidB, busyB, overrunB, tickMissB, timeoutErrB;
   logic [7:0] sarResult, resData, sarResultB, resDataB;

   logic [7:0] vals [0:3][0:3];
   int         sarCntA = 0, sarCntB = 0, doneCntA = 0, doneCntB = 0;
   bit         stallCh1;
   int         cyc = 0;
   int         lastResCyc;
   int         assertCount = 0, failCount = 0;

   always #5 clk = ~clk;

   adc_conv_scheduler #(.NUM_CH(4), .SAMPLE_PERIOD(200), .SETTLE_CYCLES(4), .AVG_LOG2(2), .TIMEOUT(32)) dut (
      .clk(clk), .reset(reset), .run(run), .ch_mask(chMask), .mux_sel(muxSel), .sh_hold(shHold),
      .sar_enable(sarEnable), .sar_done(sarDone), .sar_result(sarResult), .res_data(resData),
      .res_ch(resCh), .res_valid(resValid), .res_ready(resReady), .busy(busy), .overrun(overrun),
      .tick_miss(tickMiss), .timeout_err(timeoutErr)
   );

   adc_conv_scheduler #(.NUM_CH(4), .SAMPLE_PERIOD(40), .SETTLE_CYCLES(4), .AVG_LOG2(2), .TIMEOUT(32)) dutB (
      .clk(clk), .reset(reset), .run(runB), .ch_mask(chMaskB), .mux_sel(muxSelB), .sh_hold(shHoldB),
      .sar_enable(sarEnableB), .sar_done(sarDoneB), .sar_result(sarResultB), .res_data(resDataB),
      .res_ch(resChB), .res_valid(resValidB), .res_ready(1'b1), .busy(busyB), .overrun(overrunB),
      .tick_miss(tickMissB), .timeout_err(timeoutErrB)
   );

   // SAR models: done rises 9 cycles after enable rises and holds until enable falls;
   // the k-th conversion of a channel returns vals[channel][k].
   always @(posedge clk) begin
      cyc <= cyc + 1;
      sarCntA <= sarEnable ? sarCntA + 1 : 0;
      sarCntB <= sarEnableB ? sarCntB + 1 : 0;
      if (sarEnable && sarDone) doneCntA <= doneCntA + 1;
      if (sarEnableB && sarDoneB) doneCntB <= doneCntB + 1;
   end

   assign sarDone    = sarEnable && (sarCntA >= 9) && !(stallCh1 && muxSel == 2'd1);
   assign sarResult  = vals[muxSel][doneCntA[1:0]];
   assign sarDoneB   = sarEnableB && (sarCntB >= 9);
   assign sarResultB = vals[muxSelB][doneCntB[1:0]];

   function automatic int expCode(input int ch);
      int s = 0;
      for (int k = 0; k < 4; k++) s += int'(vals[ch][k]);
      return s / 4;
   endfunction

   task automatic newVals();
      for (int c = 0; c < 4; c++)
         for (int k = 0; k < 4; k++)
            vals[c][k] = 8'($urandom_range(255));
   endtask

   task automatic applyStimulus(input logic runV, input logic [3:0] maskV, input logic readyV);
      run      = runV;
      chMask   = maskV;
      resReady = readyV;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic waitBusy(input logic level, input int limit, input string tag);
      int n = 0;
      while (busy !== level && n < limit) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, busy, level);
   endtask

   task automatic checkResult(input string tag, input int expCh, input int expData, input int limit);
      int n = 0;
      while (resValid !== 1'b1 && n < limit) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_found"}, resValid, 1);
      checkOutput({tag, "_ch"}, resCh, expCh);
      checkOutput({tag, "_data"}, resData, expData);
      checkOutput({tag, "_mux"}, muxSel, expCh);
      lastResCyc = cyc;
   endtask

   initial begin
      int t0, n, cnt, extra;
      int qCh[$];
      int qData[$];

      reset = 1'b1;
      runB = 1'b0;
      chMaskB = 4'hF;
      stallCh1 = 1'b0;
      applyStimulus(1'b0, 4'h0, 1'b1);
      for (int c = 0; c < 4; c++)
         for (int k = 0; k < 4; k++)
            vals[c][k] = 8'(8'h40 + k);
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_enable_hold", {sarEnable, shHold}, 0);
      checkOutput("rst_valid", resValid, 0);
      checkOutput("rst_data", {muxSel, resCh, resData}, 0);
      checkOutput("rst_pulses", {overrun, tickMiss, timeoutErr}, 0);
      reset = 1'b0;
      @(negedge clk);

      // Basic sweep over channels 0 and 2 with fixed codes 40..43.
      applyStimulus(1'b1, 4'b0101, 1'b1);
      @(negedge clk);
      checkOutput("start_busy_low", busy, 0);
      @(negedge clk);
      checkOutput("start_busy_high", busy, 1);
      checkOutput("settle_mux", muxSel, 0);
      checkOutput("settle_track", {shHold, sarEnable}, 0);
      t0 = cyc;
      checkResult("sw1_ch0", 0, 8'h41, 200);
      checkOutput("sw1_latency", lastResCyc - t0, 47);
      @(negedge clk);
      checkResult("sw1_ch2", 2, 8'h41, 200);
      @(negedge clk);
      checkOutput("sw1_busy_end", busy, 0);

      newVals();
      waitBusy(1'b1, 300, "sw2_start");
      checkOutput("sweep_period", cyc - t0, 200);
      checkResult("sw2_ch0", 0, expCode(0), 200);
      @(negedge clk);
      checkResult("sw2_ch2", 2, expCode(2), 200);
      @(negedge clk);

      // Handshake: consumer stalled for a whole sweep.
      newVals();
      applyStimulus(1'b1, 4'b0101, 1'b0);
      waitBusy(1'b1, 300, "hs_start");
      checkResult("hs_ch0", 0, expCode(0), 200);
      cnt = 0;
      n = 0;
      while (busy === 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
         if (overrun === 1'b1) cnt++;
      end
      checkOutput("hs_overrun_count", cnt, 1);
      checkOutput("hs_valid_held", resValid, 1);
      checkOutput("hs_ch", resCh, 2);
      checkOutput("hs_data", resData, expCode(2));
      resReady = 1'b1;
      @(negedge clk);
      checkOutput("hs_valid_drop", resValid, 0);

      // Timeout: channel 1 never completes.
      newVals();
      stallCh1 = 1'b1;
      applyStimulus(1'b1, 4'hF, 1'b1);
      waitBusy(1'b1, 300, "to_start");
      checkResult("to_ch0", 0, expCode(0), 200);
      t0 = lastResCyc;
      @(negedge clk);
      extra = 0;
      n = 0;
      while (timeoutErr !== 1'b1 && n < 100) begin
         if (resValid === 1'b1) extra++;
         @(negedge clk);
         n++;
      end
      checkOutput("to_pulse", timeoutErr, 1);
      checkOutput("to_latency", cyc - t0, 37);
      checkOutput("to_enable_low", {sarEnable, shHold}, 0);
      checkOutput("to_busy_low", busy, 0);
      @(negedge clk);
      checkOutput("to_pulse_width", timeoutErr, 0);
      checkOutput("to_no_result", extra + int'(resValid), 0);
      stallCh1 = 1'b0;
      newVals();
      waitBusy(1'b1, 300, "post_to_start");
      for (int c = 0; c < 4; c++) begin
         checkResult($sformatf("post_to_ch%0d", c), c, expCode(c), 200);
         @(negedge clk);
      end
      checkOutput("post_to_busy_end", busy, 0);

      // Empty mask across three ticks, then run drops during a conversion.
      chMask = 4'h0;
      cnt = 0;
      repeat (600) begin
         @(negedge clk);
         if (busy === 1'b1) cnt++;
      end
      checkOutput("empty_busy", cnt, 0);
      newVals();
      applyStimulus(1'b1, 4'b0011, 1'b0);
      waitBusy(1'b1, 300, "rd_start");
      checkResult("rd_ch0", 0, expCode(0), 200);
      n = 0;
      while (sarEnable !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("rd_in_convert", sarEnable, 1);
      repeat (3) @(negedge clk);
      run = 1'b0;
      @(negedge clk);
      checkOutput("rd_idle_outputs", {sarEnable, shHold, busy, muxSel}, 0);
      checkOutput("rd_valid_kept", resValid, 1);
      checkOutput("rd_data_kept", resData, expCode(0));
      checkOutput("rd_ch_kept", resCh, 0);
      resReady = 1'b1;
      @(negedge clk);
      checkOutput("rd_valid_drop", resValid, 0);

      // Asynchronous reset in the middle of a channel 2 conversion.
      newVals();
      applyStimulus(1'b1, 4'b0101, 1'b0);
      waitBusy(1'b1, 20, "ar_start");
      checkResult("ar_ch0", 0, expCode(0), 200);
      n = 0;
      while (!(muxSel === 2'd2 && sarEnable === 1'b1) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("ar_in_convert", {muxSel, sarEnable}, 3'b101);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checkOutput("ar_outputs_zero", {muxSel, shHold, sarEnable, busy, resValid, resCh}, 0);
      checkOutput("ar_data_zero", resData, 0);
      @(negedge clk);
      reset = 1'b0;
      resReady = 1'b1;
      @(negedge clk);
      checkOutput("ar_restart_busy_low", busy, 0);
      @(negedge clk);
      checkOutput("ar_restart_busy_high", busy, 1);
      checkOutput("ar_restart_mux", muxSel, 0);
      checkResult("ar_restart_ch0", 0, expCode(0), 200);
      @(negedge clk);
      checkResult("ar_restart_ch2", 2, expCode(2), 200);
      @(negedge clk);
      run = 1'b0;

      // Tick miss on the short-period instance sweeping all four channels.
      newVals();
      runB = 1'b1;
      n = 0;
      while (busyB !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("tm_start", busyB, 1);
      cnt = 0;
      n = 0;
      while (busyB === 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
         if (tickMissB === 1'b1) cnt++;
         if (resValidB === 1'b1) begin
            qCh.push_back(int'(resChB));
            qData.push_back(int'(resDataB));
         end
      end
      checkOutput("tm_pulses", cnt, 4);
      checkOutput("tm_result_count", qCh.size(), 4);
      for (int c = 0; c < 4 && c < qCh.size(); c++) begin
         checkOutput($sformatf("tm_ch%0d_ch", c), qCh[c], c);
         checkOutput($sformatf("tm_ch%0d_data", c), qData[c], expCode(c));
      end
      runB = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/adc_conv_scheduler.md
# adc_conv_scheduler

Conversion scheduler for the discrete SAR ADC. It sweeps the enabled analog channels at a fixed sample rate. For each channel it drives the input mux and the sample-and-hold, then sequences the SAR FSM (enable/done) for 2^AVG_LOG2 back-to-back conversions and averages the codes. The averaged 8-bit result is presented on a valid/ready port, and the block sits between the SAR FSM and the system-side consumer.

## Interface
Parameters:
- NUM_CH, 4: number of mux channels (2..16).
- SAMPLE_PERIOD, 1000: cycles between sweep starts (must be ≥ 2).
- SETTLE_CYCLES, 8: mux/S&H settle cycles before the first conversion of a channel (≥ 1).
- AVG_LOG2, 2: log2 of the number of conversions averaged per channel (0..4).
- TIMEOUT, 64: maximum cycles allowed in one conversion before it is aborted.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level; high enables periodic sweeps.
- ch_mask  in  NUM_CH  enabled channels; bit i is channel i.
- mux_sel  out  $clog2(NUM_CH)  analog mux select.
- sh_hold  out  1  1 = hold, 0 = track.
- sar_enable  out  1  to SAR FSM enable.
- sar_done  in  1  from SAR FSM done.
- sar_result  in  8  SAR FSM trial value; valid when sar_done=1.
- res_data  out  8  averaged code.
- res_ch  out  $clog2(NUM_CH)  channel of res_data.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts.
- busy  out  1  sweep in progress.
- overrun  out  1  one-cycle pulse: an unconsumed result was overwritten.
- tick_miss  out  1  one-cycle pulse: a sweep tick arrived while busy.
- timeout_err  out  1  one-cycle pulse: a conversion was aborted.

## Operation
- Reset values: all outputs are 0. State is IDLE, and the counters and accumulator are 0.
- States: IDLE, WAIT_TICK, SETTLE, CONVERT, TRACK.
- IDLE:
  - Outputs are low and the tick counter is cleared.
  - When run=1, go to WAIT_TICK with the tick counter at SAMPLE_PERIOD-1, so the first tick fires on the next cycle.
- Tick counter:
  - Runs whenever run=1, independent of state.
  - Fires when it reaches SAMPLE_PERIOD-1, then wraps to 0.
- WAIT_TICK, on a tick:
  - Latch ch_mask.
  - If the latched mask is 0, the tick is ignored and the block stays in WAIT_TICK.
  - Otherwise select the lowest set channel, set busy=1, and go to SETTLE.
- SETTLE:
  - mux_sel equals the current channel, sh_hold=0, sar_enable=0.
  - Lasts exactly SETTLE_CYCLES cycles, then goes to CONVERT.
- CONVERT:
  - sh_hold=1 and sar_enable=1.
  - On the edge that samples sar_done=1, add sar_result to the accumulator (width 8+AVG_LOG2, unsigned) and go to TRACK.
- TRACK lasts one cycle with sh_hold=0 and sar_enable=0.
  - If fewer than 2^AVG_LOG2 conversions are done, go back to CONVERT. The mux stays put and there is no re-settle.
  - Otherwise go to SETTLE for the next higher set bit in the latched mask.
  - If no higher bit is set, go to WAIT_TICK with busy=0.
- Result capture:
  - On the edge that samples the final sar_done of a channel, load res_data = (accumulator + sar_result) >> AVG_LOG2 (truncating).
  - On the same edge, load res_ch and set res_valid=1, then clear the accumulator.
- Output handshake:
  - res_valid drops on the edge where res_valid and res_ready are both 1, unless a new result loads on the same edge. In that case the new result wins, res_valid stays 1, and overrun does not pulse.
  - Loading a new result while res_valid=1 and res_ready=0 overwrites the old result and pulses overrun.
  - The sweep never stalls on res_ready.
- Dropped tick: a tick that fires while busy=1 is dropped and pulses tick_miss.
- Timeout:
  - If CONVERT lasts TIMEOUT cycles without sar_done, drop sar_enable and sh_hold.
  - Pulse timeout_err, discard the channel's accumulator and any remaining channels, and go to WAIT_TICK with busy=0.
- run=0 in any state:
  - On the next edge go to IDLE and drop sar_enable, sh_hold, and busy.
  - Discard any partial accumulation.
  - A pending res_valid/res_data is retained until consumed.
- Asynchronous reset mid-sweep forces every output to its reset value immediately.

## Timing
- sar_enable is 0 for at least 1 cycle between consecutive conversions, so the SAR FSM restarts cleanly.
- Per-channel latency from entering SETTLE to res_valid=1 is SETTLE_CYCLES + Σ(conversion cycles) + (2^AVG_LOG2 − 1) TRACK cycles.
- One conversion lasts from the first sar_enable=1 cycle through the cycle in which sar_done is sampled.
- The first tick occurs 1 cycle after run rises, so busy rises 2 cycles after run rises.
- Status pulses (overrun, tick_miss, timeout_err) are exactly 1 cycle and registered.

## Test plan
Bench settings: NUM_CH=4, SAMPLE_PERIOD=200, SETTLE_CYCLES=4, AVG_LOG2=2, TIMEOUT=32. The SAR model raises done 9 cycles after enable rises and holds it until enable falls.
- Basic sweep:
  - Stimulus: ch_mask=4'b0101, run=1, model returns 8'h40, 8'h41, 8'h42, 8'h43; res_ready=1.
  - Response: results (ch0, 8'h41) then (ch2, 8'h41), mux_sel 0 then 2, busy low after ch2, next sweep 200 cycles after the first.
- Handshake:
  - Stimulus: res_ready=0 throughout a 2-channel sweep.
  - Response: the ch0 result is overwritten by ch2 and overrun pulses exactly once. Raising res_ready then drops res_valid after one cycle.
- Tick miss:
  - Stimulus: SAMPLE_PERIOD=40 with ch_mask=4'b1111.
  - Response: the sweep exceeds 40 cycles, so tick_miss pulses and the sweep in progress is unaffected.
- Timeout:
  - Stimulus: the model never asserts done on ch1.
  - Response: timeout_err pulses after 32 CONVERT cycles, sar_enable=0, no ch1/ch2/ch3 result, and the next tick sweeps normally.
- Empty mask and run drop:
  - Stimulus: ch_mask=0 for 3 ticks; then run=0 during CONVERT.
  - Response: busy stays 0 during the empty-mask ticks. After run drops, IDLE on the next edge with sar_enable=0 and the pending result retained.
- Asynchronous reset:
  - Stimulus: assert reset mid-CONVERT, between clock edges.
  - Response: all outputs 0 immediately. After release, with run=1, the first sweep starts cleanly from ch0.
